uart_rx_core: RTL

- Serial UART receiver: recovers 8-bit bytes from the asynchronous rxd pin line.
- Counterpart of the existing tx path: same 16x oversampling, LSB-first framing, idle-high line.
- Sits between the board rxd pin and the FND display logic. rx_data drives the two 7-segment nibble decoders.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_core.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, parity modes and oversampling constants.
// Used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    // Sample window around mid-bit; the last index marks the end of a bit period.
    localparam logic [3:0] SAMPLE_LO   = 4'd7;
    localparam logic [3:0] SAMPLE_HI   = 4'd9;
    localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks.
// A synchronous restart realigns the phase to an external event.
module uart_baud_tick #(
    parameter int DIV = 326
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, LSB-first, optional parity, idle-high line.
// Each bit is decided by a 2-of-3 vote on samples 7, 8 and 9 of its period.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 326,
    parameter int PARITY    = 0,
    parameter int INVERT_RX = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);
    localparam logic       PAR_ENABLED = (PARITY == PARITY_EVEN) || (PARITY == PARITY_ODD);
    localparam logic       PAR_ODD     = (PARITY == PARITY_ODD);

    logic [1:0]           rx_sync;
    logic                 line;
    uart_state_t          state, state_next;
    logic                 tick;
    logic                 restart;
    logic [3:0]           s_cnt;
    logic [2:0]           bit_cnt;
    logic                 samp_lo, samp_mid;
    logic                 maj;
    logic                 sample_point, bit_end;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err_q;
    logic                 wait_ok;
    logic                 shift_en, par_capture, bit_adv;
    logic                 valid_next, ferr_next, perr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
        end
    end

    assign line = rx_sync[1] ^ (INVERT_RX != 0);

    uart_baud_tick #(
        .DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    assign maj          = majority3(samp_lo, samp_mid, line);
    assign sample_point = tick && (s_cnt == SAMPLE_HI);
    assign bit_end      = tick && (s_cnt == SAMPLE_LAST);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        restart     = 1'b0;
        shift_en    = 1'b0;
        par_capture = 1'b0;
        bit_adv     = 1'b0;
        valid_next  = 1'b0;
        ferr_next   = 1'b0;
        perr_next   = 1'b0;
        case (state)
            IDLE: begin
                if (!line) begin
                    state_next = START;
                    restart    = 1'b1;
                end
            end
            START: begin
                if (sample_point && maj) begin
                    state_next = IDLE;
                end else if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                shift_en = sample_point;
                if (bit_end) begin
                    bit_adv = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (PAR_ENABLED) begin
                            state_next = uart_pkg::PARITY;
                        end else begin
                            state_next = STOP;
                        end
                    end
                end
            end
            uart_pkg::PARITY: begin
                par_capture = sample_point;
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            // Decide mid stop bit so a start edge right after it is not missed.
            STOP: begin
                if (sample_point) begin
                    if (!maj) begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HIGH;
                    end else if (par_err_q) begin
                        perr_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (tick && wait_ok && line) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_cnt     <= '0;
            bit_cnt   <= '0;
            par_err_q <= 1'b0;
        end else if (restart) begin
            s_cnt     <= '0;
            bit_cnt   <= '0;
            par_err_q <= 1'b0;
        end else begin
            if (tick && (state != IDLE) && (state != WAIT_HIGH)) begin
                s_cnt <= s_cnt + 4'd1;
            end
            if (bit_adv) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (par_capture) begin
                par_err_q <= (^shift_reg) ^ maj ^ PAR_ODD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_lo   <= 1'b1;
            samp_mid  <= 1'b1;
            shift_reg <= '0;
        end else begin
            if (tick && (s_cnt == SAMPLE_LO)) begin
                samp_lo <= line;
            end
            if (tick && (s_cnt == SAMPLE_LO + 4'd1)) begin
                samp_mid <= line;
            end
            if (shift_en) begin
                shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    // wait_ok is set at a tick that finds the line high and cleared by any low
    // sample, so leaving WAIT_HIGH needs one full tick period of high line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_ok <= 1'b0;
        end else if (state != WAIT_HIGH) begin
            wait_ok <= 1'b0;
        end else if (tick) begin
            wait_ok <= line;
        end else if (!line) begin
            wait_ok <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_valid   <= valid_next;
            frame_err  <= ferr_next;
            parity_err <= perr_next;
            if (valid_next) begin
                rx_data <= shift_reg;
            end
        end
    end

endmodule
